// File: rtl/pre_arbiter_scheduler_pkg.sv
// Shared definitions for the pre-arbiter write-permission scheduler.
// Holds the FSM state encoding used by the top and its helpers.
package pre_arbiter_scheduler_pkg;

   localparam int lpPORT_NUM_DEF = 4;
   localparam int lpTIMEOUT_DEF  = 64;

   typedef enum logic [1:0] {
      lpSCH_IDLE    = 2'd0,
      lpSCH_GRANT   = 2'd1,
      lpSCH_HOLD    = 2'd2,
      lpSCH_RELEASE = 2'd3
   } sch_state_t;

endpackage

// File: rtl/pre_arbiter_scheduler_rr_priority_picker.sv
// Combinational round-robin picker: lowest requester above i_ptr, else lowest overall.
// Zero latency; no backpressure, o_any simply reports that some request is present.
module rr_priority_picker #(
   parameter int pPORT_NUM = 4,
   parameter int pIDX_W    = $clog2(pPORT_NUM)
) (
   input  logic [pPORT_NUM-1:0] i_req,
   input  logic [pIDX_W-1:0]    i_ptr,
   output logic [pPORT_NUM-1:0] o_grant,
   output logic [pIDX_W-1:0]    o_idx,
   output logic                 o_any
);

   logic [pPORT_NUM-1:0] w_masked;
   logic [pPORT_NUM-1:0] w_sel;

   always_comb begin
      w_masked = '0;
      for (int i = 0; i < pPORT_NUM; i++) begin
         w_masked[i] = i_req[i] && (i > int'(i_ptr));
      end
      // Second pass wraps to the bottom when nothing sits above the pointer.
      w_sel = (|w_masked) ? w_masked : i_req;
   end

   always_comb begin
      o_idx   = '0;
      o_grant = '0;
      o_any   = |i_req;
      for (int i = pPORT_NUM - 1; i >= 0; i--) begin
         if (w_sel[i]) begin
            o_idx = pIDX_W'(i);
         end
      end
      if (o_any) begin
         o_grant[o_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/pre_arbiter_scheduler.sv
// Round-robin write-permission scheduler with watchdog; request in IDLE -> permission 2 cycles later.
// Grants are held until done/abandon/timeout; waiting requests stay pending (level-sensitive).
module pre_arbiter_scheduler
   import pre_arbiter_scheduler_pkg::*;
#(
   parameter int pPORT_NUM = lpPORT_NUM_DEF,
   parameter int pTIMEOUT  = lpTIMEOUT_DEF
) (
   input  logic                           iclk,
   input  logic                           irst_n,
   input  logic [pPORT_NUM-1:0]           i_request,
   input  logic [pPORT_NUM-1:0]           i_done,
   output logic [pPORT_NUM-1:0]           o_w_permition,
   output logic [$clog2(pPORT_NUM)-1:0]   o_grant_id,
   output logic                           o_grant_valid,
   output logic                           o_timeout,
   output logic                           o_busy
);

   localparam int pIDX_W = $clog2(pPORT_NUM);
   localparam int pCNT_W = $clog2(pTIMEOUT + 1);

   sch_state_t            r_state, w_state_nxt;
   logic [pIDX_W-1:0]     r_ptr, w_ptr_nxt;
   logic [pCNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [pPORT_NUM-1:0]  r_perm, w_perm_nxt;
   logic [pIDX_W-1:0]     r_id, w_id_nxt;
   logic                  r_vld, w_vld_nxt;
   logic                  r_timeout, w_timeout_nxt;

   logic [pPORT_NUM-1:0]  w_pick_oh;
   logic [pIDX_W-1:0]     w_pick_idx;
   logic                  w_pick_any;

   rr_priority_picker #(
      .pPORT_NUM (pPORT_NUM),
      .pIDX_W    (pIDX_W)
   ) u_picker (
      .i_req   (i_request),
      .i_ptr   (r_ptr),
      .o_grant (w_pick_oh),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_state   <= lpSCH_IDLE;
         r_ptr     <= pIDX_W'(pPORT_NUM - 1);
         r_cnt     <= '0;
         r_perm    <= '0;
         r_id      <= '0;
         r_vld     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_perm    <= w_perm_nxt;
         r_id      <= w_id_nxt;
         r_vld     <= w_vld_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_cnt_nxt     = r_cnt;
      w_perm_nxt    = r_perm;
      w_id_nxt      = r_id;
      w_vld_nxt     = r_vld;
      w_timeout_nxt = 1'b0;
      case (r_state)
         lpSCH_IDLE: begin
            if (|i_request) begin
               w_state_nxt = lpSCH_GRANT;
            end
         end
         lpSCH_GRANT: begin
            if (w_pick_any) begin
               w_perm_nxt  = w_pick_oh;
               w_id_nxt    = w_pick_idx;
               w_vld_nxt   = 1'b1;
               w_ptr_nxt   = w_pick_idx;
               w_cnt_nxt   = '0;
               w_state_nxt = lpSCH_HOLD;
            end else begin
               w_state_nxt = lpSCH_IDLE;
            end
         end
         lpSCH_HOLD: begin
            w_cnt_nxt = r_cnt + pCNT_W'(1);
            // done outranks abandon, which outranks watchdog expiry.
            if (i_done[r_id] || !i_request[r_id] ||
                (r_cnt == pCNT_W'(pTIMEOUT - 1))) begin
               w_timeout_nxt = !i_done[r_id] && i_request[r_id];
               w_perm_nxt    = '0;
               w_id_nxt      = '0;
               w_vld_nxt     = 1'b0;
               w_state_nxt   = lpSCH_RELEASE;
            end
         end
         lpSCH_RELEASE: begin
            w_state_nxt = (|i_request) ? lpSCH_GRANT : lpSCH_IDLE;
         end
         default: begin
            w_state_nxt = lpSCH_IDLE;
         end
      endcase
   end

   assign o_w_permition = r_perm;
   assign o_grant_id    = r_id;
   assign o_grant_valid = r_vld;
   assign o_timeout     = r_timeout;
   assign o_busy        = (r_state != lpSCH_IDLE);

endmodule

// File: tb/tb_pre_arbiter_scheduler.sv
// Directed bench for pre_arbiter_scheduler: grant latency, rotation, watchdog, abandon, reset.
module tb_pre_arbiter_scheduler;

   logic       iclk = 1'b0;
   logic       irst_n;
   logic [3:0] i_request;
   logic [3:0] i_done;
   logic [3:0] o_w_permition;
   logic [1:0] o_grant_id;
   logic       o_grant_valid;
   logic       o_timeout;
   logic       o_busy;

   int total = 0;
   int bad   = 0;

   always #5 iclk = ~iclk;

   pre_arbiter_scheduler #(
      .pPORT_NUM (4),
      .pTIMEOUT  (64)
   ) dut (
      .iclk          (iclk),
      .irst_n        (irst_n),
      .i_request     (i_request),
      .i_done        (i_done),
      .o_w_permition (o_w_permition),
      .o_grant_id    (o_grant_id),
      .o_grant_valid (o_grant_valid),
      .o_timeout     (o_timeout),
      .o_busy        (o_busy)
   );

   task automatic step();
      @(posedge iclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulses reset mid-cycle (1 ns after an edge) and leaves the bench in that same cycle.
   task automatic do_reset();
      i_request = 4'b0000;
      i_done    = 4'b0000;
      irst_n    = 1'b0;
      #2;
      irst_n    = 1'b1;
   endtask

   initial begin
      int order [5];
      order = '{0, 1, 2, 3, 0};
      irst_n    = 1'b0;
      i_request = 4'b0000;
      i_done    = 4'b0000;

      // Reset state
      #12;
      chk("rst_perm",    32'(o_w_permition), 32'h0);
      chk("rst_valid",   32'(o_grant_valid), 32'h0);
      chk("rst_id",      32'(o_grant_id),    32'h0);
      chk("rst_timeout", 32'(o_timeout),     32'h0);
      chk("rst_busy",    32'(o_busy),        32'h0);
      irst_n = 1'b1;
      step();

      // Test 1: single request, latency and done
      i_request = 4'b0001;
      chk("t1_c0_perm", 32'(o_w_permition), 32'h0);
      step();
      chk("t1_c1_perm", 32'(o_w_permition), 32'h0);
      chk("t1_c1_busy", 32'(o_busy), 32'h1);
      step();
      chk("t1_c2_perm",  32'(o_w_permition), 32'h1);
      chk("t1_c2_valid", 32'(o_grant_valid), 32'h1);
      chk("t1_c2_id",    32'(o_grant_id),    32'h0);
      step();
      step();
      chk("t1_c4_perm", 32'(o_w_permition), 32'h1);
      step();
      i_done = 4'b0001;
      chk("t1_c5_perm", 32'(o_w_permition), 32'h1);
      step();
      i_done    = 4'b0000;
      i_request = 4'b0000;
      chk("t1_c6_perm",    32'(o_w_permition), 32'h0);
      chk("t1_c6_valid",   32'(o_grant_valid), 32'h0);
      chk("t1_c6_timeout", 32'(o_timeout),     32'h0);
      step();
      chk("t1_c7_busy", 32'(o_busy), 32'h0);

      // Test 2: all requesting, rotation 0,1,2,3,0
      do_reset();
      i_request = 4'b1111;
      step();
      step();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t2_grant%0d_perm", k), 32'(o_w_permition), 32'(1 << order[k]));
         chk($sformatf("t2_grant%0d_id", k),   32'(o_grant_id),    32'(order[k]));
         if (k < 4) begin
            step();
            step();
            i_done = 4'(1 << order[k]);
            step();
            i_done = 4'b0000;
            chk($sformatf("t2_gap%0d_a", k), 32'(o_w_permition), 32'h0);
            step();
            chk($sformatf("t2_gap%0d_b", k), 32'(o_w_permition), 32'h0);
            step();
         end
      end

      // Test 3: watchdog expiry 64 cycles after the permission appears
      do_reset();
      i_request = 4'b0100;
      step();
      step();
      for (int i = 0; i < 64; i++) begin
         chk($sformatf("t3_hold%0d", i), {27'h0, o_timeout, o_w_permition}, 32'h04);
         step();
      end
      chk("t3_expire_timeout", 32'(o_timeout),     32'h1);
      chk("t3_expire_perm",    32'(o_w_permition), 32'h0);
      chk("t3_expire_busy",    32'(o_busy),        32'h1);
      step();
      chk("t3_after_timeout", 32'(o_timeout),     32'h0);
      chk("t3_after_perm",    32'(o_w_permition), 32'h0);
      step();
      chk("t3_regrant_perm", 32'(o_w_permition), 32'h4);

      // Test 4: grantee 2 abandons, pending 3 follows
      i_request = 4'b1100;
      step();
      chk("t4_hold_perm", 32'(o_w_permition), 32'h4);
      i_request = 4'b1000;
      step();
      chk("t4_release_perm",    32'(o_w_permition), 32'h0);
      chk("t4_release_timeout", 32'(o_timeout),     32'h0);
      step();
      chk("t4_grant_perm", 32'(o_w_permition), 32'h0);
      step();
      chk("t4_p3_perm", 32'(o_w_permition), 32'h8);
      chk("t4_p3_id",   32'(o_grant_id),    32'h3);

      // Test 5: foreign done ignored; done coinciding with expiry suppresses timeout
      i_done = 4'b0010;
      step();
      i_done = 4'b0000;
      chk("t5_foreign_done_perm", 32'(o_w_permition), 32'h8);
      for (int i = 0; i < 62; i++) begin
         step();
      end
      chk("t5_last_hold_perm", 32'(o_w_permition), 32'h8);
      i_done = 4'b1000;
      step();
      i_done = 4'b0000;
      chk("t5_release_perm",    32'(o_w_permition), 32'h0);
      chk("t5_release_timeout", 32'(o_timeout),     32'h0);
      step();
      chk("t5_next_timeout", 32'(o_timeout), 32'h0);
      step();
      chk("t5_regrant_perm", 32'(o_w_permition), 32'h8);

      // Test 6: async reset mid-HOLD, then 1010 grants port 1 then port 3
      irst_n = 1'b0;
      #2;
      chk("t6_async_perm",    32'(o_w_permition), 32'h0);
      chk("t6_async_valid",   32'(o_grant_valid), 32'h0);
      chk("t6_async_busy",    32'(o_busy),        32'h0);
      chk("t6_async_timeout", 32'(o_timeout),     32'h0);
      i_request = 4'b1010;
      irst_n    = 1'b1;
      step();
      chk("t6_c1_perm", 32'(o_w_permition), 32'h0);
      step();
      chk("t6_p1_perm", 32'(o_w_permition), 32'h2);
      chk("t6_p1_id",   32'(o_grant_id),    32'h1);
      i_done = 4'b0010;
      step();
      i_done = 4'b0000;
      chk("t6_release_perm", 32'(o_w_permition), 32'h0);
      step();
      step();
      chk("t6_p3_perm", 32'(o_w_permition), 32'h8);
      chk("t6_p3_id",   32'(o_grant_id),    32'h3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
